lfsr_gen: RTL

LFSR_GEN -- requirements
Module: lfsr_gen

---
 rtl/lfsr_pkg.sv | 44 ++++
 rtl/lfsr_next.sv | 31 +++
 rtl/lfsr_gen.sv | 93 +++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR generator: maximal tap masks, mode encoding, counter sizing.
// Latency: not applicable (package only).
// Backpressure: not applicable (package only).
package lfsr_pkg;

    // Mode encoding for debruijn_en
    localparam logic MODE_MAXIMAL  = 1'b0;
    localparam logic MODE_DEBRUIJN = 1'b1;

    // The step counter and period are one bit wider than the core,
    // so a full 2^WIDTH de Bruijn cycle fits.
    localparam int CNT_EXTRA_BITS = 1;

    function automatic int cnt_width(input int width);
        return width + CNT_EXTRA_BITS;
    endfunction

    // Maximal-length feedback masks over the core bits for WIDTH 3..16.
    // Bit k of the mask selects core bit k into the XOR feedback.
    // The MSB is always tapped; the remaining taps come from primitive polynomials.
    function automatic logic [15:0] max_taps(input int width);
        logic [15:0] m;
        m = 16'h0000;
        case (width)
            3:  m = 16'b0000_0000_0000_0110; // 3,2
            4:  m = 16'b0000_0000_0000_1100; // 4,3
            5:  m = 16'b0000_0000_0001_0100; // 5,3
            6:  m = 16'b0000_0000_0011_0000; // 6,5
            7:  m = 16'b0000_0000_0110_0000; // 7,6
            8:  m = 16'b0000_0000_1011_1000; // 8,6,5,4
            9:  m = 16'b0000_0001_0001_0000; // 9,5
            10: m = 16'b0000_0010_0100_0000; // 10,7
            11: m = 16'b0000_0101_0000_0000; // 11,9
            12: m = 16'b0000_1000_0010_1001; // 12,6,4,1
            13: m = 16'b0001_0000_0000_1101; // 13,4,3,1
            14: m = 16'b0010_0000_0001_0101; // 14,5,3,1
            15: m = 16'b0110_0000_0000_0000; // 15,14
            16: m = 16'b1101_0000_0000_1000; // 16,15,13,4
            default: m = 16'h0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lfsr_next.sv
// Feedback bit generator: XOR of tapped core bits, de Bruijn zero-insertion and lockup escape.
// Latency: purely combinational, zero cycles.
// Backpressure: none; evaluated every cycle, consumed only when the parent steps.
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001
) (
    input  logic [WIDTH-1:0] core,
    input  logic             debruijn_en,
    output logic             next_bit,
    output logic             lockup_hit
);

    logic fb_bit;
    logic corr_bit;
    logic core_zero;

    // Feedback parity, de Bruijn correction and all-zero escape in maximal mode
    always_comb begin
        fb_bit     = ^(core & TAPS);
        core_zero  = ~|core;
        // The correction fires when every core bit below the MSB is zero,
        // which splices the all-zero state into the maximal cycle.
        corr_bit   = (debruijn_en == MODE_DEBRUIJN) ? ~|core[WIDTH-2:0] : 1'b0;
        lockup_hit = (debruijn_en == MODE_MAXIMAL) && core_zero;
        next_bit   = lockup_hit ? 1'b1 : (fb_bit ^ corr_bit);
    end

endmodule

// File: rtl/lfsr_gen.sv
// LFSR generator with maximal/de Bruijn modes, wrap detection, period measurement and lockup flag.
// Latency: dout updates on the edge after a step/write; wrap and period appear one cycle after the qualifying step.
// Backpressure: cen low freezes all state; wrap reads 0 on any cycle without a step.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
    parameter logic [WIDTH:0]   SEED  = 5'b10000
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           wen,
    input  logic [WIDTH:0] din,
    input  logic           debruijn_en,
    output logic [WIDTH:0] dout,
    output logic           wrap,
    output logic [WIDTH:0] period,
    output logic           lockup
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH:0]   state_q;
    logic [WIDTH-1:0] start_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    period_q;
    logic             wrap_q;
    logic             lockup_q;

    logic [WIDTH-1:0] core;
    logic [WIDTH-1:0] next_core;
    logic             next_bit;
    logic             lockup_hit;
    logic             wrap_hit;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .core        (core),
        .debruijn_en (debruijn_en),
        .next_bit    (next_bit),
        .lockup_hit  (lockup_hit)
    );

    // Core view and the core that a step would produce, for wrap comparison
    always_comb begin
        core      = state_q[WIDTH-1:0];
        next_core = {core[WIDTH-2:0], next_bit};
        wrap_hit  = (next_core == start_q);
    end

    // State, start register, step counter, period and flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= SEED;
            start_q  <= SEED[WIDTH-1:0];
            cnt_q    <= '0;
            period_q <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else if (cen && wen) begin
            // A load defines a new start point; period keeps its last value
            state_q  <= din;
            start_q  <= din[WIDTH-1:0];
            cnt_q    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else if (cen) begin
            state_q <= {core, next_bit};
            wrap_q  <= wrap_hit;
            if (wrap_hit) begin
                period_q <= cnt_q + 1'b1;
                cnt_q    <= '0;
            end else begin
                cnt_q    <= cnt_q + 1'b1;
            end
            if (lockup_hit) begin
                lockup_q <= 1'b1;
            end
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign dout   = state_q;
    assign wrap   = wrap_q;
    assign period = period_q;
    assign lockup = lockup_q;

endmodule
